// File: rtl/fc_layer_par.sv
// fc_layer_par: fully-connected layer, LANES neurons per weight fetch, bias, optional ReLU,
// arithmetic shift and saturation, streamed one neuron per output handshake.
module fc_layer_par #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH = 24,
  parameter int IN_SIZE = 16,
  parameter int OUT_SIZE = 10,
  parameter int LANES = 2,
  parameter int OUT_SHIFT = 0,
  localparam int NG = (OUT_SIZE + LANES - 1) / LANES,
  localparam int WAW = NG * IN_SIZE > 1 ? $clog2(NG * IN_SIZE) : 1,
  localparam int BAW = NG > 1 ? $clog2(NG) : 1,
  localparam int IW = OUT_SIZE > 1 ? $clog2(OUT_SIZE) : 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          relu_en,
  output logic                          busy,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_WIDTH-1:0]         in_data,
  output logic [WAW-1:0]                weight_addr,
  output logic                          weight_en,
  input  logic [LANES*DATA_WIDTH-1:0]   weight_din,
  output logic [BAW-1:0]                bias_addr,
  output logic                          bias_en,
  input  logic [LANES*ACC_WIDTH-1:0]    bias_din,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic [IW-1:0]                 out_idx,
  output logic                          done
);
  localparam int CW = $clog2(IN_SIZE + 1);
  localparam int IXW = IN_SIZE > 1 ? $clog2(IN_SIZE) : 1;
  localparam int LW = LANES > 1 ? $clog2(LANES) : 1;
  typedef enum logic [2:0] {IDLE, LOAD, MAC, BIAS, DRAIN} state_t;
  state_t state, state_nxt;
  logic [CW-1:0] c;
  logic [BAW-1:0] g;
  logic [LW-1:0] lane;
  logic relu;
  logic signed [DATA_WIDTH-1:0] act [IN_SIZE];
  logic signed [ACC_WIDTH-1:0] acc [LANES];
  logic [DATA_WIDTH-1:0] res [LANES];
  logic signed [2*DATA_WIDTH-1:0] prod [LANES];
  logic signed [ACC_WIDTH-1:0] mac_nxt [LANES];
  logic signed [ACC_WIDTH-1:0] sum [LANES];
  logic signed [ACC_WIDTH-1:0] rel [LANES];
  logic signed [ACC_WIDTH-1:0] shf [LANES];
  logic [DATA_WIDTH-1:0] sat_v [LANES];
  logic [ACC_WIDTH-DATA_WIDTH:0] hi [LANES];
  logic in_fire, load_last, mac_last, bias_last, out_fire, lane_last, grp_last;
  assign busy = state != IDLE;
  assign in_ready = state == LOAD;
  assign out_valid = state == DRAIN;
  assign weight_en = state == MAC && int'(c) < IN_SIZE;
  assign weight_addr = WAW'(int'(g) * IN_SIZE + int'(c));
  assign bias_en = state == BIAS && c == '0;
  assign bias_addr = g;
  assign out_data = res[lane];
  assign out_idx = IW'(int'(g) * LANES + int'(lane));
  assign in_fire = in_valid && state == LOAD;
  assign load_last = in_fire && int'(c) == IN_SIZE - 1;
  assign mac_last = state == MAC && int'(c) == IN_SIZE;
  assign bias_last = state == BIAS && c[0];
  assign out_fire = out_valid && out_ready;
  assign lane_last = int'(lane) == LANES - 1 || int'(g) * LANES + int'(lane) + 1 >= OUT_SIZE;
  assign grp_last = int'(g) == NG - 1;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = start ? LOAD : IDLE;
      LOAD:    state_nxt = load_last ? MAC : LOAD;
      MAC:     state_nxt = mac_last ? BIAS : MAC;
      BIAS:    state_nxt = bias_last ? DRAIN : BIAS;
      DRAIN:   state_nxt = out_fire && lane_last ? (grp_last ? IDLE : MAC) : DRAIN;
      default: state_nxt = IDLE;
    endcase
  end
  // weight_din holds the word fetched in the previous MAC cycle, so it pairs with act[c-1]
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      prod[l] = act[IXW'(c - CW'(1))] * $signed(weight_din[l*DATA_WIDTH +: DATA_WIDTH]);
      mac_nxt[l] = acc[l] + ACC_WIDTH'(prod[l]);
      sum[l] = acc[l] + $signed(bias_din[l*ACC_WIDTH +: ACC_WIDTH]);
      rel[l] = relu && sum[l][ACC_WIDTH-1] ? '0 : sum[l];
      shf[l] = rel[l] >>> OUT_SHIFT;
      hi[l] = shf[l][ACC_WIDTH-1:DATA_WIDTH-1];
      sat_v[l] = (&hi[l] || ~|hi[l]) ? shf[l][DATA_WIDTH-1:0]
                                     : {shf[l][ACC_WIDTH-1], {(DATA_WIDTH-1){~shf[l][ACC_WIDTH-1]}}};
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      c <= '0;
      g <= '0;
      lane <= '0;
      relu <= 1'b0;
      done <= 1'b0;
      acc <= '{default: '0};
      res <= '{default: '0};
    end else begin
      state <= state_nxt;
      done <= state == DRAIN && state_nxt == IDLE;
      c <= (state_nxt != state || state == IDLE || state == DRAIN) ? '0 : c + CW'(state != LOAD || in_fire);
      if (state == IDLE && start) relu <= relu_en;
      if (state_nxt == MAC && state != MAC) acc <= '{default: '0};
      else if (state == MAC && c != '0) acc <= mac_nxt;
      if (bias_last) res <= sat_v;
      if (bias_last) lane <= '0;
      else if (out_fire) lane <= lane_last ? '0 : lane + LW'(1);
      if (out_fire && lane_last) g <= grp_last ? '0 : g + BAW'(1);
    end
  end
  always_ff @(posedge clk)
    if (in_fire) act[IXW'(c)] <= in_data;
endmodule

// File: tb/tb_fc_layer_par.sv
// tb_fc_layer_par: directed checks of fc_layer_par with IN=4, OUT=3, LANES=2, OUT_SHIFT=2.
module tb_fc_layer_par;
  localparam int IN = 4, OUT = 3, NG = 2;
  logic clk = 0, reset = 1, start = 0, relu_en = 0, in_valid = 0, out_ready = 1;
  logic [7:0] in_data = '0;
  logic busy, in_ready, weight_en, bias_en, out_valid, done;
  logic [2:0] weight_addr;
  logic [0:0] bias_addr;
  logic [1:0] out_idx;
  logic [7:0] out_data;
  logic [15:0] weight_din = '0;
  logic [47:0] bias_din = '0;
  logic [15:0] wmem [8];
  logic [47:0] bmem [2];
  int vectors = 0, errors = 0, we_cnt = 0;
  logic bad_idx = 0;

  fc_layer_par #(.DATA_WIDTH(8), .ACC_WIDTH(24), .IN_SIZE(IN), .OUT_SIZE(OUT), .LANES(2), .OUT_SHIFT(2)) dut (
    .clk(clk), .reset(reset), .start(start), .relu_en(relu_en), .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .weight_addr(weight_addr), .weight_en(weight_en), .weight_din(weight_din),
    .bias_addr(bias_addr), .bias_en(bias_en), .bias_din(bias_din),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_idx(out_idx), .done(done)
  );

  always #5 clk = ~clk;

  // one-cycle-latency memories plus a weight strobe counter
  always @(posedge clk) begin
    if (weight_en) weight_din <= wmem[weight_addr];
    if (bias_en) bias_din <= bmem[bias_addr];
    if (weight_en) we_cnt <= we_cnt + 1;
    if (out_valid && out_idx >= 2'(OUT)) bad_idx <= 1'b1;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic set_w(input logic [7:0] a0, input logic [7:0] a1, input logic [7:0] b0, input logic [7:0] b1);
    for (int i = 0; i < IN; i++) begin
      wmem[i] = {a1, a0};
      wmem[IN + i] = {b1, b0};
    end
  endtask

  task automatic set_b(input logic [23:0] b0, input logic [23:0] b1, input logic [23:0] b2);
    bmem[0] = {b1, b0};
    bmem[1] = {24'd0, b2};
  endtask

  task automatic run_frame(input string nm, input logic relu, input logic [31:0] xs, input logic [23:0] ev,
                           input logic stall, input logic poke);
    int we0, we_hold, t;
    logic [7:0] hd;
    logic [1:0] hx;
    @(negedge clk); start = 1; relu_en = relu;
    @(negedge clk); start = 0; relu_en = 0;
    vectors++;
    if (in_ready !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL %s load_entry: in_ready=%b busy=%b expected 1 1", nm, in_ready, busy);
    end
    we0 = we_cnt;
    for (int k = 0; k < IN; k++) begin
      in_valid = 1; in_data = xs[k*8 +: 8];
      if (k == 1 && poke) start = 1;
      @(negedge clk);
      start = 0;
    end
    in_valid = 0;
    out_ready = 1;
    for (int n = 0; n < OUT; n++) begin
      t = 0;
      while (out_valid !== 1'b1 && t < 200) begin @(negedge clk); t++; end
      vectors++;
      if (out_valid !== 1'b1 || out_idx !== 2'(n) || out_data !== ev[n*8 +: 8]) begin
        errors++;
        $display("FAIL %s out%0d: valid=%b idx=%0d data=%0d expected valid=1 idx=%0d data=%0d",
                 nm, n, out_valid, out_idx, $signed(out_data), n, $signed(ev[n*8 +: 8]));
      end
      if (stall && n == 1) begin
        out_ready = 0;
        hd = out_data; hx = out_idx; we_hold = we_cnt;
        repeat (5) begin
          @(negedge clk);
          vectors++;
          if (out_valid !== 1'b1 || out_data !== hd || out_idx !== hx || we_cnt !== we_hold) begin
            errors++;
            $display("FAIL %s stall: valid=%b data=%0d idx=%0d we=%0d expected 1 %0d %0d %0d",
                     nm, out_valid, $signed(out_data), out_idx, we_cnt, $signed(hd), hx, we_hold);
          end
        end
        out_ready = 1;
      end
      @(negedge clk);
    end
    vectors++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL %s done: done=%b busy=%b expected 1 0", nm, done, busy);
    end
    vectors++;
    if (we_cnt - we0 != NG * IN) begin
      errors++; $display("FAIL %s weight_en_count: got %0d expected %0d", nm, we_cnt - we0, NG * IN);
    end
    @(negedge clk);
    vectors++;
    if (done !== 1'b0) begin
      errors++; $display("FAIL %s done_pulse: done=%b expected 0", nm, done);
    end
  endtask

  task automatic test_reset;
    reset = 1;
    repeat (2) @(negedge clk);
    vectors++;
    if ({busy, in_ready, weight_en, bias_en, out_valid, done} !== 6'b0) begin
      errors++; $display("FAIL reset_ctrl: %b expected 000000", {busy, in_ready, weight_en, bias_en, out_valid, done});
    end
    vectors++;
    if ({weight_addr, bias_addr, out_idx, out_data} !== 14'b0) begin
      errors++; $display("FAIL reset_data: addr=%0d baddr=%0d idx=%0d data=%0d expected 0",
                         weight_addr, bias_addr, out_idx, out_data);
    end
    reset = 0;
    @(negedge clk);
  endtask

  task automatic test_basic;
    set_w(8'd1, 8'd2, 8'd3, 8'd100);
    set_b(24'd30, 24'd0, -24'sd37);
    run_frame("basic", 1'b0, {8'd4, 8'd3, 8'd2, 8'd1}, {8'hFE, 8'h05, 8'h0A}, 1'b0, 1'b0);
  endtask

  task automatic test_relu;
    set_w(8'd1, 8'd1, 8'd1, 8'd1);
    set_b(24'd0, 24'd0, -24'sd20);
    run_frame("relu_on", 1'b1, {8'd4, 8'd3, 8'd2, 8'd1}, {8'h00, 8'h02, 8'h02}, 1'b0, 1'b0);
    run_frame("relu_off", 1'b0, {8'd4, 8'd3, 8'd2, 8'd1}, {8'hFD, 8'h02, 8'h02}, 1'b0, 1'b0);
  endtask

  task automatic test_saturation;
    set_b(24'd0, 24'd0, 24'd0);
    set_w(8'd127, 8'd127, 8'd127, 8'd127);
    run_frame("sat_hi", 1'b0, {4{8'd127}}, {3{8'h7F}}, 1'b0, 1'b0);
    set_w(8'h80, 8'h80, 8'h80, 8'h80);
    run_frame("sat_lo", 1'b0, {4{8'd127}}, {3{8'h80}}, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back;
    set_w(8'd1, 8'd2, 8'd3, 8'd100);
    set_b(24'd30, 24'd0, -24'sd37);
    run_frame("stall", 1'b0, {8'd4, 8'd3, 8'd2, 8'd1}, {8'hFE, 8'h05, 8'h0A}, 1'b1, 1'b0);
  endtask

  task automatic test_reset_mid;
    @(negedge clk); start = 1;
    @(negedge clk); start = 0;
    for (int k = 0; k < IN; k++) begin in_valid = 1; in_data = 8'd9; @(negedge clk); end
    in_valid = 0;
    @(negedge clk);
    vectors++;
    if (weight_en !== 1'b1) begin
      errors++; $display("FAIL mid_mac: weight_en=%b expected 1", weight_en);
    end
    reset = 1;
    @(negedge clk);
    vectors++;
    if ({busy, in_ready, weight_en, bias_en, out_valid, done, weight_addr, bias_addr, out_idx, out_data} !== 20'b0) begin
      errors++; $display("FAIL mid_reset: busy=%b we=%b addr=%0d idx=%0d data=%0d expected all 0",
                         busy, weight_en, weight_addr, out_idx, out_data);
    end
    reset = 0;
    run_frame("after_reset", 1'b0, {8'd4, 8'd3, 8'd2, 8'd1}, {8'hFE, 8'h05, 8'h0A}, 1'b0, 1'b1);
    repeat (4) begin
      @(negedge clk);
      vectors++;
      if (busy !== 1'b0) begin
        errors++; $display("FAIL busy_start_ignored: busy=%b expected 0", busy);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_relu();
    test_saturation();
    test_back_to_back();
    test_reset_mid();
    vectors++;
    if (bad_idx !== 1'b0) begin
      errors++; $display("FAIL skipped_lane: out_idx>=%0d presented=%b expected 0", OUT, bad_idx);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
